// File: rtl/ctrl_soma3b.sv
// Operand loader and result capture for a 3-bit ripple adder, with a
// synchronised, debounced pushbutton that steps the load/show sequence.
module ctrl_soma3b #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       btn,
    input  logic       clr,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    input  logic [3:0] s_in,
    output logic [3:0] result,
    output logic       result_valid,
    output logic [1:0] state_code
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A   = 2'b00,
        LOAD_B   = 2'b01,
        WAIT_SUM = 2'b10,
        SHOW     = 2'b11
    } state_t;

    logic             sync1;
    logic             btn_s;
    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;
    logic             press;
    state_t           state;

    // Synchroniser and debounce; press fires on the same edge btn_db rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            btn_s  <= 1'b0;
            btn_db <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
            press <= 1'b0;
            if (btn_s != btn_db) begin
                if (db_cnt == CNT_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                    press  <= btn_s;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Load/show sequence; clr takes priority over any press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_A;
            a_out        <= 3'd0;
            b_out        <= 3'd0;
            result       <= 4'd0;
            result_valid <= 1'b0;
        end else if (clr) begin
            state        <= LOAD_A;
            a_out        <= 3'd0;
            b_out        <= 3'd0;
            result       <= 4'd0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        a_out <= sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_out <= sw;
                        state <= WAIT_SUM;
                    end
                end
                WAIT_SUM: begin
                    result       <= s_in;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        result_valid <= 1'b0;
                        state        <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_ctrl_soma3b.sv
// Directed bench for ctrl_soma3b with DEBOUNCE_CYCLES=4 and a behavioural adder.
module tb_ctrl_soma3b;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw;
    logic       btn;
    logic       clr;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic [3:0] s_in;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] state_code;

    int checks;
    int failures;

    ctrl_soma3b #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn          (btn),
        .clr          (clr),
        .a_out        (a_out),
        .b_out        (b_out),
        .s_in         (s_in),
        .result       (result),
        .result_valid (result_valid),
        .state_code   (state_code)
    );

    assign s_in = {1'b0, a_out} + {1'b0, b_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         op;      // 0 idle, 1 press, 2 clr pulse
        logic [2:0] sw;
        logic [1:0] st;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] r;
        logic       v;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] a,
                             input logic [2:0] b, input logic [3:0] r, input logic v);
        check({tag, ".state"}, int'(state_code), int'(st));
        check({tag, ".a"}, int'(a_out), int'(a));
        check({tag, ".b"}, int'(b_out), int'(b));
        check({tag, ".result"}, int'(result), int'(r));
        check({tag, ".valid"}, int'(result_valid), int'(v));
    endtask

    // Clean press: hold long enough to debounce, release long enough to settle.
    task automatic do_press(input logic [2:0] val);
        @(negedge clk);
        sw  = val;
        btn = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        btn = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[9];
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        sw    = 3'd0;
        btn   = 1'b0;
        clr   = 1'b0;

        vecs[0] = '{1, 3'd3, 2'b01, 3'd3, 3'd0, 4'd0,  1'b0};
        vecs[1] = '{1, 3'd5, 2'b11, 3'd3, 3'd5, 4'd8,  1'b1};
        vecs[2] = '{1, 3'd0, 2'b00, 3'd3, 3'd5, 4'd8,  1'b0};
        vecs[3] = '{1, 3'd7, 2'b01, 3'd7, 3'd5, 4'd8,  1'b0};
        vecs[4] = '{1, 3'd7, 2'b11, 3'd7, 3'd7, 4'd14, 1'b1};
        vecs[5] = '{1, 3'd2, 2'b00, 3'd7, 3'd7, 4'd14, 1'b0};
        vecs[6] = '{0, 3'd1, 2'b00, 3'd7, 3'd7, 4'd14, 1'b0};
        vecs[7] = '{1, 3'd6, 2'b01, 3'd6, 3'd7, 4'd14, 1'b0};
        vecs[8] = '{2, 3'd4, 2'b00, 3'd0, 3'd0, 4'd0,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 2'b00, 3'd0, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                1: do_press(vecs[i].sw);
                2: begin sw = vecs[i].sw; do_clr(); end
                default: begin
                    sw = vecs[i].sw;
                    repeat (20) @(posedge clk);
                    @(negedge clk);
                end
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b,
                      vecs[i].r, vecs[i].v);
        end

        // Short glitches must not register as a press.
        @(negedge clk); sw = 3'd5; btn = 1'b1;
        repeat (2) @(negedge clk); btn = 1'b0;
        repeat (3) @(negedge clk); btn = 1'b1;
        repeat (3) @(negedge clk); btn = 1'b0;
        repeat (15) @(negedge clk);
        check_all("glitch", 2'b00, 3'd0, 3'd0, 4'd0, 1'b0);

        // clr on the same edge as a debounced press in LOAD_B.
        do_press(3'd1);
        check("clrp.pre_state", int'(state_code), 1);
        @(negedge clk); sw = 3'd6; btn = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        check("clrp.state", int'(state_code), 0);
        check("clrp.a", int'(a_out), 0);
        check("clrp.b", int'(b_out), 0);
        @(negedge clk); clr = 1'b0; btn = 1'b0;
        repeat (12) @(negedge clk);
        check("clrp.settled", int'(state_code), 0);

        // Cycle-accurate latency: 2 sync + 4 debounce edges, then the load edge.
        @(negedge clk); sw = 3'd4; btn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat.hold%0d", k), int'(state_code), 0);
        end
        @(posedge clk); #1;
        check("lat.state", int'(state_code), 1);
        check("lat.a", int'(a_out), 4);
        @(negedge clk); btn = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-run, sampled before any further clock edge.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_all("async_rst", 2'b00, 3'd0, 3'd0, 4'd0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
